adder_tree_acc: RTL and testbench

ADDER_TREE_ACC -- requirements
Module: adder_tree_acc

---
 rtl/adder_tree_pkg.sv | 28 ++
 rtl/adder_tree_stage.sv | 57 +++++
 rtl/adder_tree_acc.sv | 197 +++++++++++++++++++
 tb/tb_adder_tree_acc.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
// Shared helpers for the adder-tree accumulator: log2, accumulator state type,
// and signed range limits used by the optional saturating accumulate.
package adder_tree_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } acc_state_e;

   // Ceiling log2; returns 0 for v <= 1.
   function automatic int unsigned log2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   function automatic logic signed [63:0] smax(input int unsigned w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] smin(input int unsigned w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One registered pairwise-add level: N_OPS signed operands of OP_W bits reduce
// to N_OPS/2 sums of OP_W+1 bits, with valid/last carried alongside.
module adder_tree_stage #(
   parameter int unsigned N_OPS = 4,
   parameter int unsigned OP_W  = 5
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             flush_i,
   input  logic                             valid_i,
   input  logic                             last_i,
   input  logic [N_OPS*OP_W-1:0]            data_i,
   output logic                             valid_o,
   output logic                             last_o,
   output logic [(N_OPS/2)*(OP_W+1)-1:0]    data_o
);

   localparam int unsigned N_OUT = N_OPS / 2;
   localparam int unsigned SUM_W = OP_W + 1;

   logic                       valid_q;
   logic                       last_q;
   logic [N_OUT*SUM_W-1:0]     sum_d;
   logic [N_OUT*SUM_W-1:0]     sum_q;

   // Each operand is sign-extended by one bit before adding, so no level can overflow.
   always_comb begin
      sum_d = '0;
      for (int unsigned i = 0; i < N_OUT; i++) begin
         sum_d[i*SUM_W +: SUM_W] =
            SUM_W'(signed'(data_i[(2*i)*OP_W +: OP_W])) +
            SUM_W'(signed'(data_i[(2*i+1)*OP_W +: OP_W]));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         sum_q   <= '0;
      end else begin
         sum_q <= sum_d;
         if (flush_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
         end else begin
            valid_q <= valid_i;
            last_q  <= last_i;
         end
      end
   end

   assign valid_o = valid_q;
   assign last_o  = last_q;
   assign data_o  = sum_q;

endmodule

// File: rtl/adder_tree_acc.sv
// Adder-tree accumulator: log2(N_IN) registered add levels feed a windowed accumulator.
// Define ADDER_TREE_SAT_EN for saturating accumulate with a sticky out_sat flag.
module adder_tree_acc
   import adder_tree_pkg::*;
#(
   parameter int unsigned N_IN   = 4,
   parameter int unsigned IN_W   = 5,
   parameter int unsigned ACC_W  = 12,
   parameter int unsigned BEAT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [N_IN*IN_W-1:0]   in_data,
   input  logic                   in_last,
   input  logic                   flush,
   output logic                   out_valid,
   output logic [ACC_W-1:0]       out_data,
   output logic [BEAT_W-1:0]      out_beats,
   output logic                   out_sat
);

   localparam int unsigned L      = log2(N_IN);
   localparam int unsigned TREE_W = IN_W + L;

   logic                      tree_valid;
   logic                      tree_last;
   logic [TREE_W-1:0]         tree_sum;

   for (genvar k = 0; k < L; k++) begin : g_lvl
      localparam int unsigned NK = N_IN >> k;
      localparam int unsigned WK = IN_W + k;

      logic                          vin;
      logic                          lin;
      logic [NK*WK-1:0]              din;
      logic                          vout;
      logic                          lout;
      logic [(NK/2)*(WK+1)-1:0]      dout;

      if (k == 0) begin : g_src
         assign vin = in_valid;
         assign lin = in_valid & in_last;
         assign din = in_data;
      end else begin : g_chain
         assign vin = g_lvl[k-1].vout;
         assign lin = g_lvl[k-1].lout;
         assign din = g_lvl[k-1].dout;
      end

      adder_tree_stage #(
         .N_OPS (NK),
         .OP_W  (WK)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .flush_i (flush),
         .valid_i (vin),
         .last_i  (lin),
         .data_i  (din),
         .valid_o (vout),
         .last_o  (lout),
         .data_o  (dout)
      );
   end

   assign tree_valid = g_lvl[L-1].vout;
   assign tree_last  = g_lvl[L-1].lout;
   assign tree_sum   = g_lvl[L-1].dout;

   acc_state_e                state_q, state_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [BEAT_W-1:0]         cnt_q, cnt_d;
   logic                      out_valid_q, out_valid_d;
   logic [ACC_W-1:0]          out_data_q, out_data_d;
   logic [BEAT_W-1:0]         out_beats_q, out_beats_d;

   logic signed [ACC_W-1:0]   acc_base;
   logic signed [ACC_W-1:0]   tree_ext;
   logic signed [ACC_W-1:0]   acc_next;
   logic [BEAT_W-1:0]         cnt_base;
   logic [BEAT_W-1:0]         cnt_next;

`ifdef ADDER_TREE_SAT_EN
   localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(smax(ACC_W));
   localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(smin(ACC_W));

   logic                      sat_win_q, sat_win_d;
   logic                      out_sat_q, out_sat_d;
   logic signed [ACC_W:0]     acc_wide;
   logic                      clamp;
   logic                      sat_next;
`endif

   // The first beat of a window uses a zero base, so loading and adding share one adder.
   always_comb begin
      acc_base = (state_q == IDLE) ? '0 : acc_q;
      cnt_base = (state_q == IDLE) ? '0 : cnt_q;
      tree_ext = ACC_W'(signed'(tree_sum));
      cnt_next = (&cnt_base) ? cnt_base : cnt_base + BEAT_W'(1);
`ifdef ADDER_TREE_SAT_EN
      acc_wide = (ACC_W+1)'(acc_base) + (ACC_W+1)'(tree_ext);
      clamp    = 1'b0;
      acc_next = acc_wide[ACC_W-1:0];
      if (acc_wide > SAT_MAX) begin
         acc_next = SAT_MAX[ACC_W-1:0];
         clamp    = 1'b1;
      end else if (acc_wide < SAT_MIN) begin
         acc_next = SAT_MIN[ACC_W-1:0];
         clamp    = 1'b1;
      end
      sat_next = ((state_q == IDLE) ? 1'b0 : sat_win_q) | clamp;
`else
      acc_next = acc_base + tree_ext;
`endif
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      out_beats_d = out_beats_q;
`ifdef ADDER_TREE_SAT_EN
      sat_win_d   = sat_win_q;
      out_sat_d   = out_sat_q;
`endif
      if (flush) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
`ifdef ADDER_TREE_SAT_EN
         sat_win_d = 1'b0;
`endif
      end else if (tree_valid) begin
         if (tree_last) begin
            state_d     = IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b1;
            out_data_d  = acc_next;
            out_beats_d = cnt_next;
`ifdef ADDER_TREE_SAT_EN
            sat_win_d   = 1'b0;
            out_sat_d   = sat_next;
`endif
         end else begin
            state_d = ACCUM;
            acc_d   = acc_next;
            cnt_d   = cnt_next;
`ifdef ADDER_TREE_SAT_EN
            sat_win_d = sat_next;
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_beats_q <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_beats_q <= out_beats_d;
      end
   end

`ifdef ADDER_TREE_SAT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_win_q <= 1'b0;
         out_sat_q <= 1'b0;
      end else begin
         sat_win_q <= sat_win_d;
         out_sat_q <= out_sat_d;
      end
   end

   assign out_sat = out_sat_q;
`else
   assign out_sat = 1'b0;
`endif

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_beats = out_beats_q;

endmodule

// File: tb/tb_adder_tree_acc.sv
// Scoreboard bench for adder_tree_acc: a 12-bit and an 8-bit accumulator instance share stimulus.
// Honours ADDER_TREE_SAT_EN to select saturating or wrapping expectations.
module tb_adder_tree_acc;

   localparam int L = 2;
`ifdef ADDER_TREE_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [19:0] in_data;
   logic        in_last;
   logic        flush;

   logic        ov12, ov8;
   logic [11:0] od12;
   logic [7:0]  od8;
   logic [7:0]  ob12, ob8;
   logic        os12, os8;

   always #5 clk = ~clk;

   adder_tree_acc #(.N_IN(4), .IN_W(5), .ACC_W(12), .BEAT_W(8)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .flush(flush), .out_valid(ov12), .out_data(od12), .out_beats(ob12), .out_sat(os12)
   );

   adder_tree_acc #(.N_IN(4), .IN_W(5), .ACC_W(8), .BEAT_W(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .flush(flush), .out_valid(ov8), .out_data(od8), .out_beats(ob8), .out_sat(os8)
   );

   typedef struct {
      int unsigned due;
      int          d12;
      int          d8;
      int          beats;
      bit          s12;
      bit          s8;
   } exp_t;

   exp_t        q[$];
   int          tests = 0;
   int          fails = 0;
   int unsigned edge_cnt = 0;

   longint m12, m8;
   int     mbeats;
   bit     ms12, ms8, min_win;
   int     h12, h8, hb;
   bit     hs12, hs8;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   function automatic int wrapw(input longint v, input int w);
      longint m, r;
      m = longint'(1) << w;
      r = ((v % m) + m) % m;
      if (r >= m / 2) r = r - m;
      return int'(r);
   endfunction

   function automatic longint accum(input longint base, input longint s, input int w, inout bit sat);
      longint r, hi, lo;
      r  = base + s;
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -(longint'(1) << (w - 1));
      if (SAT) begin
         if (r > hi) begin r = hi; sat = 1'b1; end
         else if (r < lo) begin r = lo; sat = 1'b1; end
         return r;
      end
      return longint'(wrapw(r, w));
   endfunction

   function automatic logic [19:0] pack(input int a, input int b, input int c, input int d);
      return {d[4:0], c[4:0], b[4:0], a[4:0]};
   endfunction

   function automatic int opsum(input logic [19:0] d);
      int s;
      logic signed [4:0] op;
      s = 0;
      for (int i = 0; i < 4; i++) begin
         op = d[i*5 +: 5];
         s  = s + int'(op);
      end
      return s;
   endfunction

   task automatic model_clear();
      min_win = 1'b0;
      m12 = 0; m8 = 0; mbeats = 0; ms12 = 1'b0; ms8 = 1'b0;
   endtask

   // Drives one cycle of inputs and advances the model for the edge that consumes them.
   task automatic drive(input bit v, input logic [19:0] d, input bit l, input bit f);
      exp_t e;
      int   s;
      in_valid = v; in_data = d; in_last = l; flush = f;
      if (f) begin
         model_clear();
         q.delete();
      end else if (v) begin
         s = opsum(d);
         if (!min_win) model_clear();
         mbeats = (mbeats < 255) ? mbeats + 1 : 255;
         m12 = accum(m12, longint'(s), 12, ms12);
         m8  = accum(m8,  longint'(s), 8,  ms8);
         if (l) begin
            e.due = edge_cnt + L + 1;
            e.d12 = int'(m12); e.d8 = int'(m8); e.beats = mbeats;
            e.s12 = ms12; e.s8 = ms8;
            q.push_back(e);
            min_win = 1'b0;
         end else begin
            min_win = 1'b1;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic drain(input string name);
      idle(L + 3);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL %s_drain: %0d results still pending, required 0", name, q.size());
         q.delete();
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst !== 1'b1) begin
         tests++;
         if (ov8 !== ov12) begin
            fails++;
            $display("FAIL valid_align: ov8=%b ov12=%b, required equal", ov8, ov12);
         end
         if (ov12 === 1'b1) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_out_valid at edge %0d: got pulse, required none", edge_cnt);
            end else begin
               e = q.pop_front();
               if (edge_cnt !== e.due || $signed(od12) !== e.d12 || int'(ob12) !== e.beats ||
                   os12 !== e.s12 || $signed(od8) !== e.d8 || int'(ob8) !== e.beats || os8 !== e.s8) begin
                  fails++;
                  $display("FAIL result: edge=%0d d12=%0d b12=%0d s12=%b d8=%0d b8=%0d s8=%b, required edge=%0d d12=%0d beats=%0d s12=%b d8=%0d s8=%b",
                           edge_cnt, $signed(od12), ob12, os12, $signed(od8), ob8, os8,
                           e.due, e.d12, e.beats, e.s12, e.d8, e.s8);
               end
               h12 = e.d12; h8 = e.d8; hb = e.beats; hs12 = e.s12; hs8 = e.s8;
            end
         end else begin
            tests++;
            if ($signed(od12) !== h12 || $signed(od8) !== h8 || int'(ob12) !== hb ||
                os12 !== hs12 || os8 !== hs8) begin
               fails++;
               $display("FAIL hold: d12=%0d d8=%0d beats=%0d s12=%b s8=%b, required %0d %0d %0d %b %b",
                        $signed(od12), $signed(od8), ob12, os12, os8, h12, h8, hb, hs12, hs8);
            end
         end
      end
   end

   task automatic clear_hold();
      h12 = 0; h8 = 0; hb = 0; hs12 = 1'b0; hs8 = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; flush = 1'b0;
      model_clear(); clear_hold();
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (ov12 !== 1'b0 || od12 !== 12'd0 || ob12 !== 8'd0 || os12 !== 1'b0 ||
          ov8 !== 1'b0 || od8 !== 8'd0 || ob8 !== 8'd0 || os8 !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: v=%b d=%0d b=%0d s=%b, required all zero", ov12, od12, ob12, os12);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      drive(1'b1, pack(15, 15, 15, 15), 1'b1, 1'b0);
      drain("single");
      tests++;
      if ($signed(od12) !== 60 || ob12 !== 8'd1) begin
         fails++;
         $display("FAIL single_beat: data=%0d beats=%0d, required 60 1", $signed(od12), ob12);
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, pack(1, 1, 1, 1), 1'b0, 1'b0);
      drive(1'b1, pack(2, 2, 2, 2), 1'b0, 1'b0);
      drive(1'b1, pack(-3, -3, -3, -3), 1'b1, 1'b0);
      drive(1'b1, pack(-16, -16, -16, -16), 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) drive(1'b1, pack(i, -i, 2 * i, 1), 1'b1, 1'b0);
      drive(1'b1, pack(-16, -16, -16, -16), 1'b1, 1'b0);
      drain("back_to_back");
      tests++;
      if ($signed(od12) !== -64 || ob12 !== 8'd1) begin
         fails++;
         $display("FAIL b2b_last: data=%0d beats=%0d, required -64 1", $signed(od12), ob12);
      end
   endtask

   task automatic test_gaps();
      drive(1'b1, pack(1, 1, 1, 1), 1'b0, 1'b0);
      idle(5);
      drive(1'b1, pack(2, 2, 2, 2), 1'b0, 1'b0);
      drive(1'b1, pack(-3, -3, -3, -3), 1'b1, 1'b0);
      drain("gaps");
      tests++;
      if ($signed(od12) !== 0 || ob12 !== 8'd3) begin
         fails++;
         $display("FAIL gap_window: data=%0d beats=%0d, required 0 3", $signed(od12), ob12);
      end
   endtask

   task automatic test_wrap_sat();
      drive(1'b1, pack(15, 15, 15, 15), 1'b0, 1'b0);
      drive(1'b1, pack(15, 15, 15, 15), 1'b0, 1'b0);
      drive(1'b1, pack(15, 15, 15, 15), 1'b1, 1'b0);
      drain("wrap_sat");
      tests++;
      if ($signed(od8) !== (SAT ? 127 : -76) || os8 !== SAT || $signed(od12) !== 180) begin
         fails++;
         $display("FAIL acc8_overflow: d8=%0d sat=%b d12=%0d, required %0d %b 180",
                  $signed(od8), os8, $signed(od12), SAT ? 127 : -76, SAT);
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, pack(7, 7, 7, 7), 1'b0, 1'b0);
      drive(1'b1, pack(3, 3, 3, 3), 1'b0, 1'b0);
      rst = 1'b1;
      #2;
      tests++;
      if (ov12 !== 1'b0 || od12 !== 12'd0 || ob12 !== 8'd0 || od8 !== 8'd0 || os8 !== 1'b0) begin
         fails++;
         $display("FAIL reset_async: v=%b d=%0d b=%0d, required 0 0 0", ov12, od12, ob12);
      end
      q.delete(); model_clear(); clear_hold();
      @(posedge clk); #1;
      rst = 1'b0;
      drive(1'b1, pack(1, 2, 3, 4), 1'b1, 1'b0);
      drain("reset_mid");
      tests++;
      if ($signed(od12) !== 10 || ob12 !== 8'd1) begin
         fails++;
         $display("FAIL reset_mid_result: data=%0d beats=%0d, required 10 1", $signed(od12), ob12);
      end
   endtask

   task automatic test_flush();
      drive(1'b1, pack(3, 3, 3, 3), 1'b0, 1'b0);
      drive(1'b1, pack(7, 7, 7, 7), 1'b0, 1'b1);
      idle(2);
      drive(1'b1, pack(9, 9, 9, 9), 1'b1, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b1);
      drain("flush");
      drive(1'b1, pack(5, 5, 5, 5), 1'b1, 1'b0);
      drain("flush_next");
      tests++;
      if ($signed(od12) !== 20 || ob12 !== 8'd1) begin
         fails++;
         $display("FAIL flush_next_window: data=%0d beats=%0d, required 20 1", $signed(od12), ob12);
      end
   endtask

   task automatic test_beat_sat();
      for (int i = 0; i < 299; i++) drive(1'b1, pack(1, 0, 0, 0), 1'b0, 1'b0);
      drive(1'b1, pack(1, 0, 0, 0), 1'b1, 1'b0);
      drain("beat_sat");
      tests++;
      if (ob12 !== 8'd255 || $signed(od12) !== 300) begin
         fails++;
         $display("FAIL beat_counter_sat: beats=%0d data=%0d, required 255 300", ob12, $signed(od12));
      end
   endtask

   task automatic test_random();
      logic [19:0] d;
      for (int i = 0; i < 400; i++) begin
         d = pack($urandom_range(31), $urandom_range(31), $urandom_range(31), $urandom_range(31));
         drive($urandom_range(9) < 7, d, $urandom_range(9) < 3, 1'b0);
      end
      drain("random");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_gaps();
      test_wrap_sat();
      test_reset_mid();
      test_flush();
      test_beat_sat();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
